sdram_arb: RTL and testbench

SDRAM_ARB -- requirements
Module: sdram_arb

---
 rtl/sdram_arb_pkg.sv | 31 +++
 rtl/sdram_arb_pick.sv | 39 +++
 rtl/sdram_arb.sv | 202 ++++++++++++++++++++
 tb/tb_sdram_arb.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sdram_arb_pkg                                                |
// | Description : Shared types and defaults for the SDRAM slot arbiter:        |
// |               arbiter state encoding, requester identifiers and the        |
// |               default slot length / refresh cadence.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package sdram_arb_pkg;

    // Arbiter state machine encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        REFR = 2'd2
    } state_t;

    // Requester identifiers
    typedef enum logic [1:0] {
        LD  = 2'd0,
        CPU = 2'd1,
        PPU = 2'd2
    } req_id_t;

    // Default clk cycles per SDRAM slot
    localparam int C_SLOT_CYCLES   = 16;
    // Default number of back-to-back busy slots before a forced refresh slot
    localparam int C_REFRESH_SLOTS = 8;

endpackage : sdram_arb_pkg
`default_nettype wire

// File: rtl/sdram_arb_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sdram_arb_pick                                               |
// | Description : Combinational winner selection. The loader always wins;      |
// |               CPU/PPU contention is settled by the round-robin pointer;    |
// |               a lone requester wins outright.                              |
// | Ports       : i_ld_req, i_cpu_req, i_ppu_req - request levels              |
// |               i_rr_ppu  - round-robin pointer (1 = PPU favoured)           |
// |               o_valid   - at least one requester is active                 |
// |               o_winner  - identifier of the selected requester             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sdram_arb_pick
    import sdram_arb_pkg::*;
(
    input  logic    i_ld_req,
    input  logic    i_cpu_req,
    input  logic    i_ppu_req,
    input  logic    i_rr_ppu,
    output logic    o_valid,
    output req_id_t o_winner
);

    always_comb begin
        o_valid  = i_ld_req | i_cpu_req | i_ppu_req;
        o_winner = LD;
        if (i_ld_req) begin
            o_winner = LD;
        end else if (i_cpu_req && i_ppu_req) begin
            o_winner = i_rr_ppu ? PPU : CPU;
        end else if (i_cpu_req) begin
            o_winner = CPU;
        end else if (i_ppu_req) begin
            o_winner = PPU;
        end
    end

endmodule : sdram_arb_pick
`default_nettype wire

// File: rtl/sdram_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sdram_arb                                                    |
// | Description : Slot-based arbiter sharing one SDRAM controller between a    |
// |               loader (writes), a CPU (reads/writes) and a PPU (reads).     |
// |               One access per clkref slot, each lasting SLOT_CYCLES clks;   |
// |               after REFRESH_SLOTS busy slots a slot is left idle so the    |
// |               controller can refresh.                                      |
// | Ports       : clk, reset (async, active high), clkref (slot reference)     |
// |               ld_*  - loader write request / operands / ack               |
// |               cpu_* - CPU request / operands / read data / ack            |
// |               ppu_* - PPU read request / address / read data / ack        |
// |               mem_* - command and data interface to the SDRAM controller  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sdram_arb
    import sdram_arb_pkg::*;
#(
    parameter int SLOT_CYCLES   = C_SLOT_CYCLES,
    parameter int REFRESH_SLOTS = C_REFRESH_SLOTS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clkref,
    input  logic        ld_req,
    input  logic [24:0] ld_addr,
    input  logic [7:0]  ld_din,
    output logic        ld_ack,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [24:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_ack,
    input  logic        ppu_req,
    input  logic [24:0] ppu_addr,
    output logic [7:0]  ppu_dout,
    output logic        ppu_ack,
    output logic [24:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_din,
    output logic        mem_oeA,
    output logic        mem_oeB,
    input  logic [7:0]  mem_doutA,
    input  logic [7:0]  mem_doutB
);

    localparam int c_cnt_w  = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int c_slot_w = $clog2(REFRESH_SLOTS + 1);
    localparam logic [c_cnt_w-1:0]  c_last      = c_cnt_w'(SLOT_CYCLES - 1);
    localparam logic [c_slot_w-1:0] c_slots_max = c_slot_w'(REFRESH_SLOTS);

    state_t              r_state;
    state_t              w_state_nx;
    logic                r_clkref_d;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_slot_w-1:0] r_slots;
    logic                r_rr_ppu;
    req_id_t             r_gnt;

    logic                w_slot_start;
    logic                w_last;
    logic                w_any;
    req_id_t             w_winner;
    logic                w_grant;
    logic                w_refr;

    assign w_slot_start = clkref & ~r_clkref_d;
    assign w_last       = (r_cnt == c_last);

    sdram_arb_pick u_pick (
        .i_ld_req  (ld_req),
        .i_cpu_req (cpu_req),
        .i_ppu_req (ppu_req),
        .i_rr_ppu  (r_rr_ppu),
        .o_valid   (w_any),
        .o_winner  (w_winner)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next state; a pending request at a slot boundary is either granted or,
    // once the busy-slot budget is spent, turned into a refresh slot.
    always_comb begin
        w_state_nx = r_state;
        w_grant    = 1'b0;
        w_refr     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_slot_start && w_any) begin
                    if (r_slots == c_slots_max) begin
                        w_state_nx = REFR;
                        w_refr     = 1'b1;
                    end else begin
                        w_state_nx = BUSY;
                        w_grant    = 1'b1;
                    end
                end
            end
            BUSY, REFR: begin
                if (w_last) begin
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Datapath: operand latching, strobes, capture and acks
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clkref_d <= 1'b0;
            r_cnt      <= '0;
            r_slots    <= '0;
            r_rr_ppu   <= 1'b0;
            r_gnt      <= LD;
            mem_addr   <= '0;
            mem_din    <= '0;
            mem_we     <= 1'b0;
            mem_oeA    <= 1'b0;
            mem_oeB    <= 1'b0;
            cpu_dout   <= '0;
            ppu_dout   <= '0;
            ld_ack     <= 1'b0;
            cpu_ack    <= 1'b0;
            ppu_ack    <= 1'b0;
        end else begin
            r_clkref_d <= clkref;
            ld_ack     <= 1'b0;
            cpu_ack    <= 1'b0;
            ppu_ack    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_slot_start && !w_any) begin
                        // An unused slot gives the controller time to refresh
                        r_slots <= '0;
                    end else if (w_refr) begin
                        r_slots <= '0;
                        r_cnt   <= '0;
                    end else if (w_grant) begin
                        r_cnt   <= '0;
                        r_slots <= r_slots + 1'b1;
                        r_gnt   <= w_winner;
                        case (w_winner)
                            CPU: begin
                                mem_addr <= cpu_addr;
                                mem_din  <= cpu_din;
                                mem_we   <= cpu_we;
                                mem_oeA  <= ~cpu_we;
                                r_rr_ppu <= ~r_rr_ppu;
                            end
                            PPU: begin
                                mem_addr <= ppu_addr;
                                mem_oeB  <= 1'b1;
                                r_rr_ppu <= ~r_rr_ppu;
                            end
                            default: begin
                                mem_addr <= ld_addr;
                                mem_din  <= ld_din;
                                mem_we   <= 1'b1;
                            end
                        endcase
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        mem_we  <= 1'b0;
                        mem_oeA <= 1'b0;
                        mem_oeB <= 1'b0;
                        case (r_gnt)
                            CPU: begin
                                cpu_ack <= 1'b1;
                                if (mem_oeA) begin
                                    cpu_dout <= mem_doutA;
                                end
                            end
                            PPU: begin
                                ppu_ack  <= 1'b1;
                                ppu_dout <= mem_doutB;
                            end
                            default: ld_ack <= 1'b1;
                        endcase
                    end
                end
                REFR: begin
                    r_cnt <= r_cnt + 1'b1;
                end
                default: r_cnt <= '0;
            endcase
        end
    end

endmodule : sdram_arb
`default_nettype wire

// File: tb/tb_sdram_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sdram_arb                                                 |
// | Description : Directed self-checking bench for sdram_arb. clkref has a     |
// |               20-clk period (high 10, low 10); a monitor logs grants and   |
// |               acks, and the directed sequence compares against             |
// |               hand-derived values.                                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sdram_arb;

    logic        clk;
    logic        reset;
    logic        clkref;
    logic        ld_req;
    logic [24:0] ld_addr;
    logic [7:0]  ld_din;
    logic        ld_ack;
    logic        cpu_req;
    logic        cpu_we;
    logic [24:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_ack;
    logic        ppu_req;
    logic [24:0] ppu_addr;
    logic [7:0]  ppu_dout;
    logic        ppu_ack;
    logic [24:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_din;
    logic        mem_oeA;
    logic        mem_oeB;
    logic [7:0]  mem_doutA;
    logic [7:0]  mem_doutB;

    int errors = 0;
    int checks = 0;

    sdram_arb #(.SLOT_CYCLES(16), .REFRESH_SLOTS(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .clkref    (clkref),
        .ld_req    (ld_req),
        .ld_addr   (ld_addr),
        .ld_din    (ld_din),
        .ld_ack    (ld_ack),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_din   (cpu_din),
        .cpu_dout  (cpu_dout),
        .cpu_ack   (cpu_ack),
        .ppu_req   (ppu_req),
        .ppu_addr  (ppu_addr),
        .ppu_dout  (ppu_dout),
        .ppu_ack   (ppu_ack),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_din   (mem_din),
        .mem_oeA   (mem_oeA),
        .mem_oeB   (mem_oeB),
        .mem_doutA (mem_doutA),
        .mem_doutB (mem_doutB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // clkref: 20-clk period, updated on the falling edge
    int   ph;
    logic ref_rise;
    initial begin : g_clkref
        logic old;
        ph       = 19;
        clkref   = 1'b0;
        ref_rise = 1'b0;
        forever begin
            @(negedge clk);
            ph       = (ph + 1) % 20;
            old      = clkref;
            clkref   = (ph < 10);
            ref_rise = clkref && !old;
        end
    end

    // Monitor: grant/ack log
    int          seq[$];
    int          ack_cyc[$];
    int          grant_cyc = 0;
    int          strobe_len = 0;
    int          last_lat = 0;
    int          last_len = 0;
    int          ld_ok = 0;
    logic        any_prev = 1'b0;
    logic [24:0] g_addr = '0;
    logic [7:0]  g_din = '0;
    logic        g_we = 1'b0;
    logic        g_oeA = 1'b0;
    logic        g_oeB = 1'b0;

    always @(negedge clk) begin : b_mon
        logic any;
        any = mem_we | mem_oeA | mem_oeB;
        if (any && !any_prev) begin
            grant_cyc  = cyc;
            strobe_len = 0;
            g_addr     = mem_addr;
            g_din      = mem_din;
            g_we       = mem_we;
            g_oeA      = mem_oeA;
            g_oeB      = mem_oeB;
            if (mem_we && mem_din == ld_din && mem_addr == ld_addr && ld_req) ld_ok++;
        end
        if (any) strobe_len++;
        any_prev = any;
        if (ld_ack | cpu_ack | ppu_ack) begin
            last_lat = cyc - grant_cyc;
            last_len = strobe_len;
            seq.push_back(ld_ack ? 0 : (cpu_ack ? 1 : 2));
            ack_cyc.push_back(cyc);
        end
    end

    initial begin : g_watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int count_seq(input int v);
        int n = 0;
        foreach (seq[i]) if (seq[i] == v) n++;
        return n;
    endfunction

    task automatic do_reset();
        reset   = 1'b1;
        ld_req  = 1'b0;
        cpu_req = 1'b0;
        ppu_req = 1'b0;
        tick();
        tick();
        seq.delete();
        ack_cyc.delete();
        ld_ok = 0;
        for (int k = 0; k < 40 && clkref; k++) tick();
        reset = 1'b0;
    endtask

    task automatic wait_acks(input int n, input int budget, input string tag);
        int k = 0;
        while (seq.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk({tag, "_timeout"}, 32'(seq.size() >= n), 1);
    endtask

    task automatic wait_rise(input string tag);
        int k = 0;
        tick();
        while (!ref_rise && k < 40) begin
            tick();
            k++;
        end
        chk({tag, "_rise_timeout"}, 32'(ref_rise), 1);
    endtask

    initial begin : g_main
        int bad;
        int early;
        reset     = 1'b1;
        ld_req    = 1'b0;
        ld_addr   = 25'h1ABCDE;
        ld_din    = 8'hC3;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 25'h000123;
        cpu_din   = 8'h00;
        ppu_req   = 1'b0;
        ppu_addr  = 25'h0ABCDE;
        mem_doutA = 8'h00;
        mem_doutB = 8'h00;

        // Reset state
        tick();
        tick();
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_oe", 32'({mem_oeA, mem_oeB}), 0);
        chk("rst_acks", 32'({ld_ack, cpu_ack, ppu_ack}), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_dout", 32'({cpu_dout, ppu_dout, mem_din}), 0);

        // CPU read of 0x000123
        do_reset();
        cpu_we    = 1'b0;
        cpu_addr  = 25'h000123;
        mem_doutA = 8'h5A;
        cpu_req   = 1'b1;
        wait_acks(1, 60, "s1");
        cpu_req = 1'b0;
        chk("s1_addr", 32'(g_addr), 32'h000123);
        chk("s1_oeA_only", 32'({g_oeA, g_oeB, g_we}), 32'b100);
        chk("s1_strobe_len", 32'(last_len), 16);
        chk("s1_latency", 32'(last_lat), 16);
        chk("s1_cpu_dout", 32'(cpu_dout), 32'h5A);
        tick();
        chk("s1_ack_pulse", 32'(cpu_ack), 0);
        mem_doutA = 8'h33;
        for (int k = 0; k < 40; k++) tick();
        chk("s1_ack_once", 32'(seq.size()), 1);
        chk("s1_dout_hold", 32'(cpu_dout), 32'h5A);

        // CPU and PPU contending for 4 slots
        do_reset();
        mem_doutA = 8'h3C;
        mem_doutB = 8'hA5;
        cpu_we    = 1'b0;
        cpu_req   = 1'b1;
        ppu_req   = 1'b1;
        wait_acks(4, 150, "s2");
        cpu_req = 1'b0;
        ppu_req = 1'b0;
        chk("s2_order", 32'({seq[0][3:0], seq[1][3:0], seq[2][3:0], seq[3][3:0]}), 32'h1212);
        chk("s2_cpu_acks", 32'(count_seq(1)), 2);
        chk("s2_ppu_acks", 32'(count_seq(2)), 2);
        chk("s2_ppu_dout", 32'(ppu_dout), 32'hA5);
        chk("s2_cpu_dout", 32'(cpu_dout), 32'h3C);

        // Loader precedence, rr pointer left alone
        do_reset();
        ld_addr = 25'h1ABCDE;
        ld_din  = 8'hC3;
        ld_req  = 1'b1;
        cpu_req = 1'b1;
        ppu_req = 1'b1;
        wait_acks(3, 100, "s3");
        ld_req = 1'b0;
        chk("s3_ld_acks", 32'(count_seq(0)), 3);
        chk("s3_ld_writes", 32'(ld_ok), 3);
        chk("s3_no_cpu_ppu", 32'(count_seq(1) + count_seq(2)), 0);
        wait_acks(4, 60, "s3b");
        cpu_req = 1'b0;
        ppu_req = 1'b0;
        chk("s3_rr_cpu_next", 32'(seq[3]), 1);

        // Forced refresh slot after 8 busy slots
        do_reset();
        cpu_we  = 1'b0;
        cpu_req = 1'b1;
        wait_acks(9, 400, "s4");
        cpu_req = 1'b0;
        bad = 0;
        for (int k = 1; k < 8; k++) if (ack_cyc[k] - ack_cyc[k-1] != 20) bad++;
        chk("s4_gap20", 32'(bad), 0);
        chk("s4_refresh_gap", 32'(ack_cyc[8] - ack_cyc[7]), 40);

        // Reset at count 7 of a PPU read
        do_reset();
        ppu_req = 1'b1;
        for (int k = 0; k < 40 && !mem_oeB; k++) tick();
        chk("s5_granted", 32'(mem_oeB), 1);
        for (int k = 0; k < 7; k++) tick();
        reset = 1'b1;
        #1;
        chk("s5_strobe_drop", 32'({mem_oeB, mem_oeA, mem_we}), 0);
        tick();
        tick();
        for (int k = 0; k < 40 && clkref; k++) tick();
        reset = 1'b0;
        chk("s5_no_ack", 32'(seq.size()), 0);
        early = 0;
        for (int k = 0; k < 40 && !ref_rise; k++) begin
            tick();
            if (mem_oeB) early++;
        end
        chk("s5_wait_slot", 32'(early + int'(mem_oeB)), 0);
        tick();
        chk("s5_regrant", 32'(mem_oeB), 1);
        wait_acks(1, 40, "s5");
        ppu_req = 1'b0;
        chk("s5_latency", 32'(last_lat), 16);

        // Request raised one clk after slot_start (CPU write)
        do_reset();
        wait_rise("s6a");
        tick();
        cpu_we   = 1'b1;
        cpu_addr = 25'h0F0F0F;
        cpu_din  = 8'h77;
        cpu_req  = 1'b1;
        early = 0;
        for (int k = 0; k < 40 && !ref_rise; k++) begin
            tick();
            if (mem_we | mem_oeA | mem_oeB) early++;
        end
        chk("s6_no_early_grant", 32'(early), 0);
        tick();
        chk("s6_write_strobe", 32'({mem_we, mem_oeA}), 32'b10);
        chk("s6_write_data", 32'({mem_addr, mem_din}), 32'({25'h0F0F0F, 8'h77}));
        wait_acks(1, 40, "s6");
        cpu_req = 1'b0;
        chk("s6_latency", 32'(last_lat), 16);
        chk("s6_cpu_ack", 32'(seq[0]), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sdram_arb
`default_nettype wire
